// File: rtl/lsu_sequencer_pkg.sv
// rtl/lsu_sequencer_pkg.sv - shared types, size codes and lane helpers for the LSU sequencer
// Contents:
//   state_e      sequencer state encoding
//   SZ_*         access size codes as carried in funct3[1:0]
//   F3_SIZE_*    bit positions of the size field within funct3
//   lanemask()   byte-lane mask of an aligned access of a given size
//   size_bytes() number of bytes moved by a given size code
package lsu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam int F3_SIZE_LSB = 0;
    localparam int F3_SIZE_MSB = 1;

    function automatic logic [3:0] lanemask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational byte-lane steering for both beats of an access
// Ports:
//   size, off      size code and byte offset within the first word
//   beat           0 = merging the first beat, 1 = merging the second beat
//   wdata          right-aligned store data
//   rdata          word returned by memory for the current beat
//   acc            partial load result collected from the first beat
//   be0/wdata0     byte enables and lane-aligned data for the first beat
//   be1/wdata1     byte enables and lane-aligned data for the second beat
//   rdata_merged   right-aligned load result after this beat, masked to size
module lsu_lane_align
    import lsu_sequencer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [31:0] acc,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata_merged
);

    logic [3:0]  lm;
    logic [2:0]  roff;
    logic [5:0]  sh0;
    logic [5:0]  sh1;
    logic [31:0] size_mask;

    assign lm   = lanemask(size);
    // Bytes of the first word that the access occupies; the second beat picks up the rest.
    assign roff = 3'd4 - {1'b0, off};
    assign sh0  = {1'b0, off, 3'b000};
    assign sh1  = {roff, 3'b000};

    // Shifts beyond the word simply drop lanes; off=0 yields an empty second beat.
    assign be0    = lm << off;
    assign be1    = lm >> roff;
    assign wdata0 = wdata << sh0;
    assign wdata1 = wdata >> sh1;

    assign size_mask = {{8{lm[3]}}, {8{lm[2]}}, {8{lm[1]}}, {8{lm[0]}}};

    assign rdata_merged = (beat ? (acc | (rdata << sh1)) : (rdata >> sh0)) & size_mask;

endmodule

// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - multi-cycle load/store sequencer to a byte-enabled word memory
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata load/store request from the datapath
//   stall                         hold the pipeline while an access is in flight
//   rsp_valid/rdata/err           one-cycle completion with right-aligned load data
//   mem_req/we/addr/be/wdata      registered memory beat, held until mem_ack
//   mem_ack/rdata                 memory beat completion and read word
module lsu_sequencer
    import lsu_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int          CNT_W    = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  split_q, split_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           res_q, res_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [1:0]  req_size;
    logic        unused_funct3_sign;
    logic        timed_out;
    logic [1:0]  al_size, al_off;
    logic [31:0] al_wdata, al_wdata0, al_wdata1, al_rdata;
    logic [3:0]  al_be0, al_be1;

    assign req_size           = req_funct3[F3_SIZE_MSB:F3_SIZE_LSB];
    // Sign handling lives in the downstream load path.
    assign unused_funct3_sign = req_funct3[2];

    // In IDLE the first beat is built straight from the request; afterwards from the latched copy.
    assign al_size  = (state_q == ST_IDLE) ? req_size       : size_q;
    assign al_off   = (state_q == ST_IDLE) ? req_addr[1:0]  : off_q;
    assign al_wdata = (state_q == ST_IDLE) ? req_wdata      : wdata_q;

    lsu_lane_align u_align (
        .size         (al_size),
        .off          (al_off),
        .beat         (state_q == ST_ACC1),
        .wdata        (al_wdata),
        .rdata        (mem_rdata),
        .acc          (res_q),
        .be0          (al_be0),
        .be1          (al_be1),
        .wdata0       (al_wdata0),
        .wdata1       (al_wdata1),
        .rdata_merged (al_rdata)
    );

    assign timed_out = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TMO_LAST);

    assign stall = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_ACC0) || (state_q == ST_ACC1);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    split_d = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
                    cnt_d   = '0;
                    res_d   = '0;
                    if (req_size == SZ_ILL) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACC0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = al_be0;
                        mem_wdata_d = al_wdata0;
                    end
                end
            end
            ST_ACC0, ST_ACC1: begin
                // An ack in the timeout cycle still completes the beat.
                if (mem_ack) begin
                    res_d = al_rdata;
                    if ((state_q == ST_ACC0) && split_q) begin
                        state_d     = ST_ACC1;
                        cnt_d       = '0;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
                        mem_be_d    = al_be1;
                        mem_wdata_d = al_wdata1;
                    end else begin
                        state_d     = ST_RESP;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? 32'h0 : al_rdata;
                    end
                end else if (timed_out) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb/tb_lsu_sequencer.sv - scoreboard bench for lsu_sequencer
module tb_lsu_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    beat_t       exp_beat_q[$];
    rsp_t        exp_rsp_q[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    lsu_sequencer #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic we);
        beat_t b;
        b.addr = addr; b.be = be; b.wdata = wdata; b.we = we;
        exp_beat_q.push_back(b);
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic err);
        rsp_t r;
        r.rdata = rdata; r.err = err;
        exp_rsp_q.push_back(r);
    endtask

    // Byte-by-byte reference: each byte of the access lands in lane addr[1:0] of its own word.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1);
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1, res, a, w0;
        int          n, lane;
        bit          two;
        be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; res = '0; two = 1'b0;
        w0 = addr & 32'hFFFF_FFFC;
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            a    = addr + 32'(i);
            lane = int'(a[1:0]);
            if ((a & 32'hFFFF_FFFC) == w0) begin
                be0[lane]          = 1'b1;
                wd0[8*lane +: 8]   = wdata[8*i +: 8];
                res[8*i +: 8]      = rd0[8*lane +: 8];
            end else begin
                two                = 1'b1;
                be1[lane]          = 1'b1;
                wd1[8*lane +: 8]   = wdata[8*i +: 8];
                res[8*i +: 8]      = rd1[8*lane +: 8];
            end
        end
        push_beat(w0, be0, wd0, we);
        rd_q.push_back(rd0);
        if (two) begin
            push_beat(w0 + 32'd4, be1, wd1, we);
            rd_q.push_back(rd1);
        end
        push_rsp(we ? 32'h0 : res, 1'b0);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Acts as the memory: acks each beat after ack_delay waiting cycles and checks beats
    // and the response against the scoreboard. exp_left = beats expected never to be acked.
    task automatic serve(input int ack_delay, input int exp_left, input int budget,
                         output int rsp_cycle, output int req_cycles);
        int    w;
        bit    done;
        beat_t b;
        rsp_t  r;
        w = 0; done = 1'b0; rsp_cycle = 0; req_cycles = 0;
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                done      = 1'b1;
                rsp_cycle = c;
                req_valid = 1'b0;
                mem_ack   = 1'b0;
                vectors++;
                if (exp_rsp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rdata=%08h err=%0b, required no response", rsp_rdata, rsp_err);
                end else begin
                    r = exp_rsp_q.pop_front();
                    if (rsp_rdata !== r.rdata || rsp_err !== r.err || stall !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rsp: got rdata=%08h err=%0b stall=%0b, required rdata=%08h err=%0b stall=0",
                                 rsp_rdata, rsp_err, stall, r.rdata, r.err);
                    end
                end
                vectors++;
                if (exp_beat_q.size() != exp_left) begin
                    miscompares++;
                    $display("FAIL beats_left: got %0d pending beats, required %0d", exp_beat_q.size(), exp_left);
                end
                exp_beat_q.delete();
            end else begin
                vectors++;
                if (stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall: got %0b in cycle %0d, required 1", stall, c);
                end
                if (mem_req === 1'b1) begin
                    req_cycles++;
                    vectors++;
                    if (exp_beat_q.size() == 0) begin
                        miscompares++;
                        mem_ack = 1'b0;
                        $display("FAIL beat_unexpected: got addr=%08h be=%b, required no beat", mem_addr, mem_be);
                    end else begin
                        b = exp_beat_q[0];
                        if (mem_addr !== b.addr || mem_be !== b.be || mem_we !== b.we ||
                            (b.we && ((mem_wdata & be2mask(b.be)) !== (b.wdata & be2mask(b.be))))) begin
                            miscompares++;
                            $display("FAIL beat: got addr=%08h be=%b we=%0b wdata=%08h, required addr=%08h be=%b we=%0b wdata=%08h",
                                     mem_addr, mem_be, mem_we, mem_wdata, b.addr, b.be, b.we, b.wdata);
                        end
                        if (w >= ack_delay) begin
                            void'(exp_beat_q.pop_front());
                            mem_ack   = 1'b1;
                            mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                            w = 0;
                        end else begin
                            mem_ack = 1'b0;
                            w++;
                        end
                    end
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got no rsp_valid within %0d cycles, required a response", budget);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: got stall=%0b rsp_valid=%0b err=%0b mem_req=%0b we=%0b rdata=%08h addr=%08h be=%b wdata=%08h, required all 0",
                     stall, rsp_valid, rsp_err, mem_req, mem_we, rsp_rdata, mem_addr, mem_be, mem_wdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_aligned_store();
        int rc, nq;
        push_beat(32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
        push_rsp(32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        serve(2, 0, 20, rc, nq);
        vectors++;
        if (rc != 5) begin
            miscompares++;
            $display("FAIL store_latency: got rsp in cycle %0d, required 5", rc);
        end
    endtask

    task automatic test_byte_load();
        int rc, nq;
        push_beat(32'h200, 4'b1000, 32'h0, 1'b0);
        rd_q.push_back(32'hAABBCCDD);
        push_rsp(32'h000000AA, 1'b0);
        issue(1'b0, 3'b100, 32'h203, 32'h0);
        serve(0, 0, 20, rc, nq);
        vectors++;
        if (rc != 3) begin
            miscompares++;
            $display("FAIL byte_latency: got rsp in cycle %0d, required 3", rc);
        end
    endtask

    task automatic test_misaligned_load();
        int rc, nq;
        push_beat(32'h0FC, 4'b1100, 32'h0, 1'b0);
        push_beat(32'h100, 4'b0011, 32'h0, 1'b0);
        rd_q.push_back(32'h11223344);
        rd_q.push_back(32'h55667788);
        push_rsp(32'h77881122, 1'b0);
        issue(1'b0, 3'b010, 32'h0FE, 32'h0);
        serve(0, 0, 20, rc, nq);
        vectors++;
        if (rc != 4 || nq != 2) begin
            miscompares++;
            $display("FAIL split_latency: got rsp cycle %0d req cycles %0d, required 4 and 2", rc, nq);
        end
    endtask

    task automatic test_wrap_store();
        int rc, nq;
        push_beat(32'hFFFFFFFC, 4'b1000, 32'hCD000000, 1'b1);
        push_beat(32'h00000000, 4'b0001, 32'h000000AB, 1'b1);
        push_rsp(32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD);
        serve(1, 0, 20, rc, nq);
    endtask

    task automatic test_timeout();
        int rc, nq;
        push_beat(32'h40, 4'b1111, 32'h0, 1'b0);
        push_rsp(32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        mem_rdata = 32'hFFFFFFFF;
        serve(1000, 1, 20, rc, nq);
        vectors++;
        if (nq != 4 || rc != 6) begin
            miscompares++;
            $display("FAIL timeout_len: got req cycles %0d rsp cycle %0d, required 4 and 6", nq, rc);
        end
    endtask

    task automatic test_ack_vs_timeout();
        int rc, nq;
        push_beat(32'h44, 4'b1111, 32'h0, 1'b0);
        rd_q.push_back(32'h01020304);
        push_rsp(32'h01020304, 1'b0);
        issue(1'b0, 3'b010, 32'h44, 32'h0);
        serve(3, 0, 20, rc, nq);
        vectors++;
        if (rc != 6) begin
            miscompares++;
            $display("FAIL ack_wins_latency: got rsp cycle %0d, required 6", rc);
        end
    endtask

    task automatic test_illegal();
        int rc, nq;
        push_rsp(32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h300, 32'h0);
        serve(0, 0, 20, rc, nq);
        vectors++;
        if (nq != 0 || rc != 2) begin
            miscompares++;
            $display("FAIL illegal: got req cycles %0d rsp cycle %0d, required 0 and 2", nq, rc);
        end
    endtask

    task automatic test_rst_mid_access();
        int rc, nq;
        issue(1'b0, 3'b010, 32'h0FE, 32'h0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0FC) begin
            miscompares++;
            $display("FAIL rst_acc0: got mem_req=%0b addr=%08h, required 1 and 000000fc", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b0011) begin
            miscompares++;
            $display("FAIL rst_acc1: got mem_req=%0b addr=%08h be=%b, required 1 00000100 0011", mem_req, mem_addr, mem_be);
        end
        mem_ack   = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got mem_req=%0b stall=%0b rsp_valid=%0b, required 0 0 0", mem_req, stall, rsp_valid);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_quiet: got rsp_valid=%0b mem_req=%0b, required 0 0", rsp_valid, mem_req);
            end
        end
        push_beat(32'h80, 4'b1111, 32'h0, 1'b0);
        rd_q.push_back(32'hCAFEF00D);
        push_rsp(32'hCAFEF00D, 1'b0);
        issue(1'b0, 3'b010, 32'h80, 32'h0);
        serve(0, 0, 20, rc, nq);
    endtask

    task automatic test_back_to_back();
        int          rc, nq;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd0, rd1;
        for (int k = 0; k < 12; k++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            addr  = $urandom;
            wdata = $urandom;
            rd0   = $urandom;
            rd1   = $urandom;
            model_push(we, f3, addr, wdata, rd0, rd1);
            issue(we, f3, addr, wdata);
            serve($urandom_range(0, 2), 0, 30, rc, nq);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        test_reset();
        test_aligned_store();
        test_byte_load();
        test_misaligned_load();
        test_wrap_store();
        test_timeout();
        test_ack_vs_timeout();
        test_illegal();
        test_rst_mid_access();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
Multi-cycle memory access sequencer between the load/store datapath and a word-wide, byte-enabled data memory with a req/ack handshake. It accepts one load or store per request and stalls the core until the access completes. It converts byte addresses and funct3 sizes into word accesses with byte enables, and splits misaligned halfword/word accesses into two word beats. Load data is returned right-aligned and zero-filled; sign extension remains in the downstream load path.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a beat waits for mem_ack before abort; 0 disables the timeout
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  load/store request present (held by core while stall=1)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 size/sign field; [1:0]: 00=byte, 01=half, 10=word, 11=illegal
req_addr  in  ADDR_WIDTH  byte address (base + imm, already computed)
req_wdata  in  32  store data, right-aligned
stall  out  1  hold PC and pipeline
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load data right-aligned, unused upper bytes 0; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: illegal size or timeout
mem_req  out  1  memory beat request, registered
mem_we  out  1  beat is a write
mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=00
mem_be  out  4  byte enables, active-high, bit n = byte lane n
mem_wdata  out  32  lane-aligned write data
mem_ack  in  1  beat done; sampled only while mem_req=1
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset: state=IDLE. stall, rsp_valid, rsp_err, mem_req and mem_we are 0. rsp_rdata, mem_addr, mem_be and mem_wdata are 0.
- stall = (state==IDLE && req_valid) || state==ACC0 || state==ACC1. It is 0 in RESP.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: when req_valid=1, register we, addr, wdata, size (1/2/4) and off=addr[1:0]. Set split = (off+size > 4).
  - If funct3[1:0]==11, go to RESP with err=1 and issue no memory beat.
  - Otherwise go to ACC0, with mem_req=1 in the next cycle.
- ACC0: mem_addr={addr[31:2],00}. lanemask = 0001/0011/1111 for size 1/2/4. mem_be=(lanemask<<off)[3:0]. mem_wdata=(wdata<<8*off)[31:0].
  - On mem_ack: capture rdata>>8*off into the result low bytes.
  - If split, go to ACC1. Otherwise go to RESP with mem_req=0.
- ACC1: mem_addr = word address + 4, with modulo-2^ADDR_WIDTH wrap (0xFFFFFFFC -> 0x00000000). mem_be=lanemask>>(4-off). mem_wdata=wdata>>8*(4-off).
  - On mem_ack: merge rdata<<8*(4-off) into the result, masked to size bytes. Go to RESP.
- mem_req stays high and mem_addr/be/wdata/we stay stable until mem_ack. There is no beat-to-beat gap: ACC0->ACC1 keeps mem_req=1 with new fields on the next cycle.
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata is masked to size bytes. Always return to IDLE. req_valid is ignored in RESP, because the completing instruction is still presented.
- Timeout: an 8+ bit beat counter clears on entry to ACC0/ACC1. If it reaches TIMEOUT_CYCLES without ack: drop mem_req, go to RESP with rsp_err=1 and rsp_rdata=0. A split store that times out in ACC1 leaves beat 0 committed; this is not rolled back.
- Simultaneous ack and timeout in the same cycle: the ack wins.
- rst mid-access: IDLE at the next edge with mem_req=0. The memory must tolerate an abandoned beat.
- Minimum latency: aligned access with same-cycle ack = 3 cycles (IDLE, ACC0, RESP). Split access = 4 cycles.

Decomposition:
- Shared package: state encoding, size codes (SZ_B/SZ_H/SZ_W), funct3 field positions, and the lanemask function.
- One sub-module is natural: lsu_lane_align. It is combinational and produces be/wdata shift for both beats plus read merge from size, off and beat index.

Test Plan:
- Aligned word store: addr 0x100, wdata 0xDEADBEEF, ack after 2 cycles -> one beat with mem_addr 0x100, be 1111, wdata 0xDEADBEEF; rsp_valid on cycle 5; stall low at RESP.
- Byte load: addr 0x203, mem_rdata 0xAABBCCDD -> be 1000, rsp_rdata 0x000000AA, rsp_err 0.
- Misaligned word load: addr 0x0FE, rdata beats 0x11223344 then 0x55667788 -> beats at 0x0FC (be 1100) and 0x100 (be 0011); rsp_rdata 0x77881122.
- Wrap split store: half at 0xFFFFFFFF, wdata 0xABCD -> beat 0 at 0xFFFFFFFC (be 1000, wdata 0xCD000000); beat 1 at 0x00000000 (be 0001, wdata 0x000000AB).
- Timeout: TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops after 4 cycles; rsp_valid=1, rsp_err=1, rsp_rdata 0. Illegal funct3 011 -> rsp_err with no mem_req.
- rst asserted in ACC1 of a split load -> next cycle IDLE, mem_req 0, stall 0, no rsp_valid. A following aligned load completes normally.
